// File: rtl/rv32i_types.sv
// Shared RV32 type definitions used across the EX-stage blocks.
package rv32i_types;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } muldiv_funct3_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// signed ops run on magnitudes and the final value is negated from latched signs.
module ex_muldiv
   import rv32i_types::*;
#(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [width-1:0] rs1,
   input  logic [width-1:0] rs2,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [width-1:0] result
);

   localparam int CW = $clog2(width);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_nxt;
   muldiv_funct3_t     op_f3, op_in;
   logic [2*width-1:0] acc, acc_nxt;
   logic [width-1:0]   opnd;
   logic [CW-1:0]      cnt;
   logic               neg;

   logic               sgn_a, sgn_b, neg_in, div_zero, div_ovf, special, go, last;
   logic [width-1:0]   mag_a, mag_b, special_val;
   logic [width:0]     sum, trial;

   // Final sign fix-up and selection of the architecturally visible word.
   function automatic logic [width-1:0] finish(input muldiv_funct3_t f, input logic n,
                                               input logic [2*width-1:0] a);
      logic [2*width-1:0] p;
      logic [width-1:0]   q, r;
      p = n ? -a : a;
      q = n ? -a[width-1:0] : a[width-1:0];
      r = n ? -a[2*width-1:width] : a[2*width-1:width];
      case (f)
         F3_MUL:                      finish = a[width-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: finish = p[2*width-1:width];
         F3_DIV, F3_DIVU:             finish = q;
         default:                     finish = r;
      endcase
   endfunction

   always_comb begin
      op_in    = muldiv_funct3_t'(funct3);
      sgn_a    = rs1[width-1] & (op_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
      sgn_b    = rs2[width-1] & (op_in inside {F3_MULH, F3_DIV, F3_REM});
      mag_a    = sgn_a ? -rs1 : rs1;
      mag_b    = sgn_b ? -rs2 : rs2;
      neg_in   = 1'b0;
      if (op_in inside {F3_MULH, F3_MULHSU, F3_DIV}) neg_in = sgn_a ^ sgn_b;
      else if (op_in == F3_REM)                     neg_in = sgn_a;
      div_zero = funct3[2] && (rs2 == '0);
      div_ovf  = (op_in inside {F3_DIV, F3_REM}) && (rs1 == {1'b1, {(width-1){1'b0}}})
                 && (rs2 == '1);
      special  = div_zero || div_ovf;
      if (div_zero) special_val = (op_in inside {F3_DIV, F3_DIVU}) ? '1 : rs1;
      else          special_val = (op_in == F3_DIV) ? rs1 : '0;
      go       = (state == IDLE) && start && !flush;
      last     = (cnt == CW'(width-1));
   end

   // Datapath step: acc holds {hi,lo} product or {remainder,quotient}.
   always_comb begin
      acc_nxt = acc;
      sum     = '0;
      trial   = '0;
      if (op_f3[2]) begin
         trial = acc[2*width-1:width-1] - {1'b0, opnd};
         if (!trial[width]) acc_nxt = {trial[width-1:0], acc[width-2:0], 1'b1};
         else               acc_nxt = {acc[2*width-2:0], 1'b0};
      end else begin
         sum     = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, opnd} : '0);
         acc_nxt = {sum, acc[width-1:1]};
      end
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (go) begin
            stall     = 1'b1;
            state_nxt = special ? DONE : CALC;
         end
         CALC: begin
            stall = 1'b1;
            if (flush)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = !flush;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (go) begin
            cnt <= '0;
            if (special) result <= special_val;
         end else if (state == CALC && !flush) begin
            cnt <= cnt + 1'b1;
            if (last) result <= finish(op_f3, neg, acc_nxt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (go) begin
         op_f3 <= op_in;
         neg   <= neg_in;
         acc   <= {{width{1'b0}}, mag_a};
         opnd  <= mag_b;
      end else if (state == CALC) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with an arithmetic reference model and a per-cycle checker.
module tb_ex_muldiv;

   logic        clk, rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        stall, done;
   logic [31:0] result;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_en = 0;

   int          m_c0 = -1000;
   int          m_lat = 33;
   int          m_abort = 1 << 30;
   logic [31:0] m_val = '0;
   logic [31:0] m_res = '0;
   bit          rst_prev_low = 0;

   ex_muldiv #(.width(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .flush(flush), .stall(stall), .done(done), .result(result)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib, iq;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      ia = a;
      ib = b;
      model = '0;
      case (f)
         3'd0: begin p = ua * ub; model = p[31:0]; end
         3'd1: begin p = sa * sb; model = p[63:32]; end
         3'd2: begin p = sa * ub; model = p[63:32]; end
         3'd3: begin p = ua * ub; model = p[63:32]; end
         3'd4: if (b == 0) model = 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
               else begin iq = ia / ib; model = iq; end
         3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: if (b == 0) model = a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 0;
               else begin iq = ia % ib; model = iq; end
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // Per-cycle checker against the timing/value model.
   initial begin
      bit e_stall, e_done;
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            if (rst_prev_low) m_res = '0;
            e_stall = (cyc >= m_c0) && (cyc < m_c0 + m_lat) && (cyc <= m_abort);
            e_done  = (cyc == m_c0 + m_lat) && (m_abort >= cyc);
            if (e_done) m_res = m_val;
            check("stall", {31'b0, stall}, {31'b0, e_stall});
            check("done", {31'b0, done}, {31'b0, e_done});
            check("result", result, m_res);
            rst_prev_low = !rst;
         end
      end
   end

   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      funct3  = f;
      rs1     = a;
      rs2     = b;
      start   = 1;
      m_c0    = cyc;
      m_lat   = model_lat(f, a, b);
      m_val   = model(f, a, b);
      m_abort = 1 << 30;
   endtask

   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lit_lat);
      int lat;
      check({nm, "_model"}, model(f, a, b), lit);
      launch(f, a, b);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         #2;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 0;
      check({nm, "_latency"}, lat, lit_lat);
      check({nm, "_value"}, result, lit);
   endtask

   task automatic run_abort(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int k, input bit use_rst);
      launch(f, a, b);
      repeat (k) @(negedge clk);
      start   = 0;
      m_abort = cyc;
      if (use_rst) rst = 0;
      else         flush = 1;
      @(negedge clk);
      rst   = 1;
      flush = 0;
      repeat (40) @(negedge clk);
      m_c0 = -1000;
   endtask

   initial begin
      rst = 0; start = 0; flush = 0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      rst = 1;
      chk_en = 1;
      #2;
      check("reset_result", result, 32'h0);
      check("reset_stall", {31'b0, stall}, 32'h0);

      run_op("mul_neg",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("mulh_mix",  3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 33);
      run_op("divu",      3'd5, 32'd100,       32'd7,         32'd14,        33);
      run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("remu",      3'd7, 32'd100,       32'd7,         32'd2,         33);
      run_op("div_min",   3'd4, 32'h8000_0000, 32'd2,         32'hC000_0000, 33);
      run_op("divu_big",  3'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         33);
      run_op("remu_big",  3'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
      run_op("div_zero",  3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem_zero",  3'd6, 32'd5,         32'd0,         32'd5,         1);
      run_op("divu_zero", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
      run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

      run_abort(3'd0, 32'd7, 32'd3, 10, 1'b0);
      check("flush_hold", result, 32'h8000_0000);

      @(negedge clk);
      funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd3; start = 1; flush = 1;
      @(negedge clk);
      start = 0; flush = 0;
      repeat (3) @(negedge clk);
      check("start_flush_hold", result, 32'h8000_0000);

      run_abort(3'd4, 32'd1000, 32'd7, 20, 1'b1);
      check("rst_result", result, 32'h0);
      run_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 33);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter: width, 32, operand/result width in bits (RV32M use is 32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  level request from the ID/EX control word (M-extension op present in EX).
REQ-005 SHALL have port: funct3  input  3  op select from the ID/EX instruction (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 SHALL have port: rs1  input  width  operand A (ID/EX rs1 value, post-forwarding).
REQ-007 SHALL have port: rs2  input  width  operand B (ID/EX rs2 value, post-forwarding).
REQ-008 SHALL have port: flush  input  1  abort the current op (branch mispredict or trap).
REQ-009 SHALL have port: stall  output  1  hold IF/ID and ID/EX registers.
REQ-010 SHALL have port: done  output  1  result valid this cycle.
REQ-011 SHALL have port: result  output  width  op result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE & start & !flush SHALL latch funct3, operand magnitudes and result signs, clear the iteration counter, and go to CALC.
REQ-014 IDLE & start SHALL go directly to DONE for DIV/DIVU/REM/REMU when rs2==0, and for DIV/REM when rs1==0x80000000 and rs2==0xFFFFFFFF.
REQ-015 CALC SHALL perform one shift-add (mul) or restoring-subtract (div) step per cycle, width steps total, then go to DONE after the step with counter==width-1.
REQ-016 DONE SHALL assert done for exactly one cycle and go to IDLE; start seen in DONE SHALL be ignored, since it is the same instruction still held in ID/EX.
REQ-017 stall SHALL be combinational: (IDLE & start & !flush) | CALC; stall SHALL be low in DONE.
REQ-018 Latency SHALL be: normal op start edge N -> done high in the cycle after edge N+width (33 cycles for width 32); special case -> done in the cycle after edge N.
REQ-019 MUL SHALL return product[width-1:0]; MULH/MULHSU/MULHU SHALL return product[2*width-1:width] with signed/signed, signed/unsigned and unsigned/unsigned operand interpretation.
REQ-020 Signed ops SHALL compute on magnitudes and negate the final value per the latched signs; the remainder sign SHALL equal the dividend sign.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder rs1.
REQ-022 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-023 result SHALL hold its value from DONE until the next DONE.
REQ-024 flush in any state SHALL force IDLE next cycle, with no done and no result update.
REQ-025 flush and start in the same IDLE cycle SHALL NOT start an op.

Reset
REQ-026 rst low at a clock edge SHALL force IDLE, counter 0, result 0 and done 0, including mid-CALC.
REQ-027 rst SHALL override flush and start.

Structure
REQ-028 The funct3 enum (muldiv_funct3_t) SHALL live in the shared rv32i_types package; state enum local.
REQ-029 The block SHALL be one module with no sub-module; the datapath is a 2*width accumulator/remainder register, a width operand register and a clog2(width) counter.

Verification
REQ-030 MUL rs1=7, rs2=0xFFFFFFFD -> stall high 33 cycles, done in cycle 33 with result 0xFFFFFFEB.
REQ-031 MULH 0x80000000 x 0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIVU 100/7 -> 14; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; both at 33-cycle latency.
REQ-033 DIV 5/0 -> 0xFFFFFFFF with done the cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 1-cycle latency.
REQ-034 MUL started, flush at cycle 10 -> IDLE next cycle, stall low, done never asserted, result unchanged.
REQ-035 rst low at cycle 20 of a DIV -> IDLE, result 0; a new DIVU 9/3 afterwards -> 3 with normal latency.
